// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and response signals around alu_arbiter.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_operand_1;
    logic [31:0] alu_operand_2;
    logic [31:0] alu_result;
    logic [7:0]  alu_status;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_result;
    logic [7:0]  resp_status;
    logic        resp_err;
    logic        busy;
    logic [15:0] op_count;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_result, alu_status, resp_ready,
        output req0_ready, req1_ready,
        output alu_control, alu_operand_1, alu_operand_2,
        output resp_valid, resp_id, resp_result, resp_status, resp_err,
        output busy, op_count
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_result, alu_status, resp_ready,
        input  req0_ready, req1_ready,
        input  alu_control, alu_operand_1, alu_operand_2,
        input  resp_valid, resp_id, resp_result, resp_status, resp_err,
        input  busy, op_count
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// programmable settle time and a single tagged valid/ready response channel.
//
// state | meaning
// IDLE  | ALU inputs parked at 0, granting one pending request
// EXEC  | ALU driven from latched op, settle counter running down
// RESP  | result/status held on resp_*, waiting for resp_ready
module alu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  arb_io
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      state_q;
    logic        last_grant_q;
    logic [3:0]  cnt_q;
    logic        id_q;
    logic [3:0]  ctrl_q;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [31:0] result_q;
    logic [7:0]  status_q;
    logic        err_q;
    logic        resp_valid_q;
    logic        busy_q;
    logic [15:0] op_count_q;

    logic        grant;
    logic        accept;
    logic [3:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: is_legal = 1'b1;
            default:                                               is_legal = 1'b0;
        endcase
    endfunction

    // Under contention the requester that did not win last time goes first.
    assign grant  = (arb_io.req0_valid && arb_io.req1_valid) ? ~last_grant_q
                                                              : ~arb_io.req0_valid;
    assign accept = rst_n && (state_q == IDLE)
                    && (arb_io.req0_valid || arb_io.req1_valid);
    assign sel_op = grant ? arb_io.req1_op : arb_io.req0_op;
    assign sel_a  = grant ? arb_io.req1_a  : arb_io.req0_a;
    assign sel_b  = grant ? arb_io.req1_b  : arb_io.req0_b;

    assign arb_io.req0_ready = accept && !grant;
    assign arb_io.req1_ready = accept &&  grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            id_q         <= 1'b0;
            ctrl_q       <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            result_q     <= '0;
            status_q     <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        id_q   <= grant;
                        busy_q <= 1'b1;
                        if (is_legal(sel_op)) begin
                            ctrl_q  <= sel_op;
                            opa_q   <= sel_a;
                            opb_q   <= sel_b;
                            cnt_q   <= CNT_LOAD;
                            state_q <= EXEC;
                        end else begin
                            // Illegal op never reaches the ALU, so its stale output stays hidden.
                            result_q     <= '0;
                            status_q     <= '0;
                            err_q        <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        result_q     <= arb_io.alu_result;
                        status_q     <= {arb_io.alu_status[7:2], 2'b00};
                        err_q        <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (arb_io.resp_ready) begin
                        last_grant_q <= id_q;
                        op_count_q   <= op_count_q + 16'd1;
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        ctrl_q       <= '0;
                        opa_q        <= '0;
                        opb_q        <= '0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb_io.alu_control   = ctrl_q;
    assign arb_io.alu_operand_1 = opa_q;
    assign arb_io.alu_operand_2 = opb_q;
    assign arb_io.resp_valid    = resp_valid_q;
    assign arb_io.resp_id       = id_q;
    assign arb_io.resp_result   = result_q;
    assign arb_io.resp_status   = status_q;
    assign arb_io.resp_err      = err_q;
    assign arb_io.busy          = busy_q;
    assign arb_io.op_count      = op_count_q;
endmodule
